// File: rtl/timer_a_capture_compare_pkg.sv
// Shared encodings for the Timer_A capture/compare channel: counter mode,
// capture edge select, capture input select and output-unit modes.
package timer_a_capture_compare_pkg;

    localparam logic [1:0] MC__STOP   = 2'b00;
    localparam logic [1:0] MC__UP     = 2'b01;
    localparam logic [1:0] MC__CONT   = 2'b10;
    localparam logic [1:0] MC__UPDOWN = 2'b11;

    localparam logic [1:0] CM__NONE    = 2'b00;
    localparam logic [1:0] CM__RISING  = 2'b01;
    localparam logic [1:0] CM__FALLING = 2'b10;
    localparam logic [1:0] CM__BOTH    = 2'b11;

    localparam logic [1:0] CCIS__CCIA = 2'b00;
    localparam logic [1:0] CCIS__CCIB = 2'b01;
    localparam logic [1:0] CCIS__GND  = 2'b10;
    localparam logic [1:0] CCIS__VCC  = 2'b11;

    localparam logic [2:0] OUTMOD__OUT          = 3'd0;
    localparam logic [2:0] OUTMOD__SET          = 3'd1;
    localparam logic [2:0] OUTMOD__TOGGLE_RESET = 3'd2;
    localparam logic [2:0] OUTMOD__SET_RESET    = 3'd3;
    localparam logic [2:0] OUTMOD__TOGGLE       = 3'd4;
    localparam logic [2:0] OUTMOD__RESET        = 3'd5;
    localparam logic [2:0] OUTMOD__TOGGLE_SET   = 3'd6;
    localparam logic [2:0] OUTMOD__RESET_SET    = 3'd7;

    // CM bit 0 enables rising edges, bit 1 enables falling edges.
    function automatic logic cm_hit(input logic [1:0] cm, input logic rise, input logic fall);
        return (cm[0] & rise) | (cm[1] & fall);
    endfunction

endpackage

// File: rtl/timer_a_capture_compare_output_unit.sv
// Output unit: drives OUTn from the channel (n) and channel-0 (0) events
// according to OUTMOD; a 0 event takes priority over an n event.
module timer_a_output_unit
    import timer_a_capture_compare_pkg::*;
(
    input  logic       TimerClock,
    input  logic       reset,
    input  logic [2:0] OUTMOD,
    input  logic       OUT,
    input  logic       eqn_evt,
    input  logic       eq0_evt,
    output logic       OUTn
);

    logic out_nxt;

    always_comb begin
        out_nxt = OUTn;
        case (OUTMOD)
            OUTMOD__OUT:          out_nxt = OUT;
            OUTMOD__SET:          if (eqn_evt) out_nxt = 1'b1;
            OUTMOD__TOGGLE_RESET: if (eq0_evt) out_nxt = 1'b0; else if (eqn_evt) out_nxt = !OUTn;
            OUTMOD__SET_RESET:    if (eq0_evt) out_nxt = 1'b0; else if (eqn_evt) out_nxt = 1'b1;
            OUTMOD__TOGGLE:       if (eqn_evt) out_nxt = !OUTn;
            OUTMOD__RESET:        if (eqn_evt) out_nxt = 1'b0;
            OUTMOD__TOGGLE_SET:   if (eq0_evt) out_nxt = 1'b1; else if (eqn_evt) out_nxt = !OUTn;
            OUTMOD__RESET_SET:    if (eq0_evt) out_nxt = 1'b1; else if (eqn_evt) out_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge TimerClock or posedge reset) begin
        if (reset) OUTn <= 1'b0;
        else       OUTn <= out_nxt;
    end

endmodule

// File: rtl/timer_a_capture_compare.sv
// One Timer_A capture/compare channel: owns TAxCCRn, detects compare and
// capture events, issues CCIFG/COV set pulses and feeds the output unit.
module timer_a_capture_compare
    import timer_a_capture_compare_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int WIDTH   = 16
) (
    input  logic             TimerClock,
    input  logic             reset,
    input  logic [1:0]       MC,
    input  logic [WIDTH-1:0] TAxR,
    input  logic             EQU0,
    input  logic             CAP,
    input  logic [1:0]       CM,
    input  logic [1:0]       CCIS,
    input  logic             SCS,
    input  logic [2:0]       OUTMOD,
    input  logic             OUT,
    input  logic             CCIFG,
    input  logic             CCIA,
    input  logic             CCIB,
    input  logic             wCCR,
    input  logic [WIDTH-1:0] CCRdata,
    output logic [WIDTH-1:0] TAxCCRn,
    output logic             EQUn,
    output logic             CCI,
    output logic             SCCI,
    output logic             CCIFGset,
    output logic             COVset,
    output logic             OUTn
);

    logic cci_d, cap_d, sync_hit, eqn_d, eq0_d;
    logic mc_run, rise, fall, hit, cap_stable, cap_evt;
    logic eqn_evt, eq0_src, eq0_evt;

    always_comb begin
        case (CCIS)
            CCIS__CCIA: CCI = CCIA;
            CCIS__CCIB: CCI = CCIB;
            CCIS__GND:  CCI = 1'b0;
            CCIS__VCC:  CCI = 1'b1;
        endcase
    end

    assign EQUn    = !CAP && (TAxR == TAxCCRn);
    assign mc_run  = (MC != MC__STOP);
    assign eqn_evt = EQUn && !eqn_d && mc_run;
    assign eq0_src = (CHANNEL == 0) ? EQUn : EQU0;
    assign eq0_evt = eq0_src && !eq0_d && mc_run;

    assign rise = CCI && !cci_d;
    assign fall = !CCI && cci_d;
    assign hit  = cm_hit(CM, rise, fall);

    // A CAP change in the current cycle voids both the direct and the synchronised path.
    assign cap_stable = (CAP == cap_d);
    assign cap_evt    = CAP && cap_stable && (SCS ? sync_hit : hit);

    always_ff @(posedge TimerClock or posedge reset) begin
        if (reset) begin
            TAxCCRn  <= '0;
            SCCI     <= 1'b0;
            CCIFGset <= 1'b0;
            COVset   <= 1'b0;
            cci_d    <= 1'b0;
            cap_d    <= 1'b0;
            sync_hit <= 1'b0;
            eqn_d    <= 1'b0;
            eq0_d    <= 1'b0;
        end else begin
            cci_d    <= CCI;
            cap_d    <= CAP;
            eqn_d    <= EQUn;
            eq0_d    <= eq0_src;
            sync_hit <= SCS && CAP && cap_stable && hit;
            CCIFGset <= eqn_evt || cap_evt;
            COVset   <= cap_evt && CCIFG;
            if (eqn_evt) SCCI <= CCI;
            // Bus write has priority over a captured count.
            if (wCCR)         TAxCCRn <= CCRdata;
            else if (cap_evt) TAxCCRn <= TAxR;
        end
    end

    // On channel 0 the 0 event is the n event itself, so only the n action applies.
    timer_a_output_unit u_out (
        .TimerClock (TimerClock),
        .reset      (reset),
        .OUTMOD     (OUTMOD),
        .OUT        (OUT),
        .eqn_evt    (eqn_evt),
        .eq0_evt    ((CHANNEL != 0) && eq0_evt),
        .OUTn       (OUTn)
    );

endmodule

// File: doc/timer_a_capture_compare.md
Name: timer_a_capture_compare

Overview:
- One Timer_A capture/compare channel n, downstream of the timer counter: consumes the current TAxR count and MC.
- Compare mode: produces EQUn; the channel-0 instance's EQUn drives the counter's EQU0 input.
- Capture mode: latches TAxR into TAxCCRn on selected input edges.
- Owns TAxCCRn, generates CCIFG/COV set pulses, and drives the output unit signal OUTn.

Parameters:
CHANNEL, 0, channel index; when 0, EQU0 input is ignored and internal EQUn is used as EQU0
WIDTH, 16, count/CCR width

Ports:
TimerClock  input  1  timer clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
MC  input  2  counter mode; MC__STOP suppresses compare events
TAxR  input  WIDTH  current counter value
EQU0  input  1  channel-0 equality level (output-unit modes 2,3,6,7)
CAP  input  1  1 = capture mode, 0 = compare mode
CM  input  2  capture edge: 00 none, 01 rising, 10 falling, 11 both
CCIS  input  2  input select: 00 CCIA, 01 CCIB, 10 GND, 11 VCC
SCS  input  1  1 = synchronous capture
OUTMOD  input  3  output-unit mode
OUT  input  1  OUT bit from TAxCCTLn
CCIFG  input  1  current CCIFG flag (for overflow detection)
CCIA, CCIB  input  1  external capture inputs
wCCR  input  1  bus write strobe for TAxCCRn
CCRdata  input  WIDTH  bus write data
TAxCCRn  output  WIDTH  capture/compare register
EQUn  output  1  combinational: !CAP && (TAxR == TAxCCRn)
CCI  output  1  selected capture input, combinational
SCCI  output  1  CCI latched on each EQUn event
CCIFGset  output  1  one-cycle set pulse for CCIFG
COVset  output  1  one-cycle set pulse for COV
OUTn  output  1  output-unit signal

Behaviour:
- Reset: TAxCCRn=0, OUTn=0, SCCI=0, CCIFGset=0, COVset=0; edge/sync/equality history registers=0. Applies asynchronously at any point, including mid-capture.
- wCCR: TAxCCRn<=CCRdata on the next edge, in either mode.
- Compare event: eqn_evt = EQUn && !eqn_d && MC!=MC__STOP, where eqn_d is EQUn registered.
  - Exactly one event per entry into equality; a count held at CCRn while stopped gives none.
  - On eqn_evt: CCIFGset=1 for one cycle (registered, 1-cycle latency) and SCCI<=CCI.
  - Writing TAxCCRn equal to a held TAxR gives one event when MC!=STOP.
- Capture:
  - cci_d tracks CCI each edge.
  - rise = CCI&&!cci_d; fall = !CCI&&cci_d; hit = CM-selected edge(s).
  - SCS=0: capture on the edge after detection.
  - SCS=1: one extra sync register, so latency is 2 edges.
  - On capture: TAxCCRn<=TAxR (value sampled at capture edge), CCIFGset=1.
  - COVset=1 when CCIFG=1 at that capture.
  - CCIS=10/11 constant input produces no captures.
  - Simultaneous wCCR and capture: bus write wins TAxCCRn; CCIFGset/COVset still issued.
  - Switching CAP clears the pending sync stage; no spurious capture.
- Output unit:
  - Events are eqn_evt and eq0_evt (rising edge of EQU0, or EQUn when CHANNEL==0, gated by MC!=STOP).
  - OUTn updates on the edge after the event:
    - 0 OUTn<=OUT every cycle
    - 1 set on n
    - 2 toggle on n, reset on 0
    - 3 set on n, reset on 0
    - 4 toggle on n
    - 5 reset on n
    - 6 toggle on n, set on 0
    - 7 reset on n, set on 0
  - Simultaneous n and 0 events: EQU0 action wins.
  - CHANNEL==0: modes 2,3,6,7 apply only the n action.
  - OUTMOD changes take effect on the next edge; OUTn otherwise holds.
- Arithmetic: equality only; no wrap logic needed beyond TAxR compare.

Decomposition:
- PARAMS.v gets constants: CM__NONE/RISING/FALLING/BOTH, CCIS__CCIA/CCIB/GND/VCC, OUTMOD__OUT … OUTMOD__RESET_SET. MC__* already exists there.
- Sub-module timer_a_output_unit:
  - Inputs: TimerClock, reset, OUTMOD, OUT, eqn_evt, eq0_evt.
  - Output: OUTn.
- Capture/compare/CCR logic stays in the top module.

Test Plan:
1. Compare, MC=UP, CCRn=5, TAxR stepped 3→4→5→6 → one CCIFGset pulse the edge after TAxR=5; EQUn high only while TAxR==5. MC=STOP with TAxR=5 → no pulse.
2. Capture, CM=01, SCS=0, CCIS=00, TAxR=1000, CCIA rises → TAxCCRn=1000 and CCIFGset one edge later. With SCS=1 → two edges later. CCIA falls → no capture.
3. CM=11 with CCIFG=1, CCIA toggled twice → two captures, each with CCIFGset and COVset. CCIS=11 → no capture.
4. wCCR=1, CCRdata=16'h1234 on the same edge as a capture at TAxR=50 → TAxCCRn=16'h1234; CCIFGset still pulses.
5. OUTMOD=7 (reset/set), CCRn=3, EQU0 pulses at TAxR=10 → OUTn=0 after TAxR=3, 1 after EQU0. OUTMOD=4 → toggles each EQUn. OUTMOD=0, OUT=1 → OUTn=1.
6. Reset asserted mid-sync (SCS=1, edge pending) → TAxCCRn=0 and OUTn=0 immediately; no capture after release.
